// File: rtl/serial_pattern_tx_fsm.sv
// Serial frame transmitter: sync preamble, payload MSB-first, then an idle gap.
// Define SERIAL_PATTERN_TX_PARITY_EN to append an even-parity bit after the payload.
module serial_pattern_tx_fsm #(
  parameter int unsigned      DATA_W     = 8,
  parameter int unsigned      PRE_W      = 6,
  parameter logic [PRE_W-1:0] PREAMBLE   = 6'b110011,
  parameter int unsigned      GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_valid,
  output logic              frame_done
);

  localparam int unsigned MaxPd  = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int unsigned CntMax = (MaxPd > GAP_CYCLES) ? MaxPd : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_GAP  = 3'd3;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
  localparam logic [2:0] ST_PAR  = 3'd4;
`endif
  // Where the frame tail goes once the last frame bit has been sent
  localparam logic [2:0] ST_TAIL = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

  logic [2:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              data_last;
  logic              pre_bit;

  assign data_last = (cnt_q == CntW'(DATA_W - 1));

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  logic par_q, par_d;

  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_PRE;
          cnt_d   = '0;
          shreg_d = in_data;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
          par_d   = ^in_data;
`endif
        end
      end
      ST_PRE: begin
        if (cnt_q == CntW'(PRE_W - 1)) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_DATA: begin
        shreg_d = shreg_q << 1;
        if (data_last) begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
          state_d = ST_PAR;
`else
          state_d = ST_TAIL;
`endif
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      ST_PAR: begin
        state_d = ST_TAIL;
        cnt_d   = '0;
      end
`endif
      ST_GAP: begin
        if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  // Preamble bit selected by counter, MSB of the pattern first
  always_comb begin
    pre_bit = 1'b0;
    for (int i = 0; i < int'(PRE_W); i++) begin
      if (cnt_q == CntW'(i)) pre_bit = PREAMBLE[PRE_W - 1 - i];
    end
  end

  always_comb begin
    in_ready   = (state_q == ST_IDLE);
    out_valid  = 1'b0;
    out_bit    = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_PRE: begin
        out_valid = 1'b1;
        out_bit   = pre_bit;
      end
      ST_DATA: begin
        out_valid = 1'b1;
        out_bit   = shreg_q[DATA_W-1];
`ifndef SERIAL_PATTERN_TX_PARITY_EN
        frame_done = data_last;
`endif
      end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      ST_PAR: begin
        out_valid  = 1'b1;
        out_bit    = par_q;
        frame_done = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serial_pattern_tx_fsm.sv
// Scoreboard bench for serial_pattern_tx_fsm: accepted words expand into expected
// frame bits in a queue; a monitor pops one per valid cycle and tracks the idle gap.
module tb_serial_pattern_tx_fsm;

  localparam int unsigned      DATA_W = 8;
  localparam int unsigned      PRE_W  = 6;
  localparam logic [PRE_W-1:0] PRE    = 6'b110011;
  localparam int unsigned      GAP    = 2;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_bit;
  logic              out_valid;
  logic              frame_done;

  serial_pattern_tx_fsm #(
    .DATA_W    (DATA_W),
    .PRE_W     (PRE_W),
    .PREAMBLE  (PRE),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   gap_left   = 0;
  bit   mon_en     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: preamble MSB-first, payload MSB-first, optional even parity
  function automatic void push_frame(input logic [DATA_W-1:0] w);
    logic [PRE_W-1:0] pat;
    int unsigned      nbits;
    pat = PRE;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    nbits = PRE_W + DATA_W + 1;
`else
    nbits = PRE_W + DATA_W;
`endif
    for (int i = 0; i < int'(PRE_W); i++) q.push_back('{b: pat[PRE_W-1-i], last: 1'b0});
    for (int i = 0; i < int'(DATA_W); i++)
      q.push_back('{b: w[DATA_W-1-i], last: (PRE_W + i + 1 == nbits)});
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    q.push_back('{b: ^w, last: 1'b1});
`endif
  endfunction

  // Monitor: sample just after each active edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (q.size() != 0) begin
          e = q.pop_front();
          check("out_valid", 32'(out_valid), 32'd1);
          check("in_ready_busy", 32'(in_ready), 32'd0);
          check("out_bit", 32'(out_bit), 32'(e.b));
          check("frame_done", 32'(frame_done), 32'(e.last));
          if (e.last) gap_left = GAP;
        end else begin
          check("out_valid_idle", 32'(out_valid), 32'd0);
          check("out_bit_idle", 32'(out_bit), 32'd0);
          check("frame_done_idle", 32'(frame_done), 32'd0);
          check("in_ready_idle", 32'(in_ready), 32'(gap_left == 0));
          if (gap_left > 0) gap_left--;
        end
      end
    end
  end

  // Drive one cycle's inputs at the falling edge; record any transfer in the model
  task automatic drive(input logic r, input logic v, input logic [DATA_W-1:0] d);
    rst      = r;
    in_valid = v;
    in_data  = d;
    if (r) begin
      q.delete();
      gap_left = 0;
    end else if (v && in_ready) begin
      push_frame(d);
    end
    @(negedge clk);
  endtask

  task automatic send_held(input logic [DATA_W-1:0] w);
    bit done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      done = in_ready;
      drive(1'b0, 1'b1, w);
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge clk);
    mon_en = 1'b1;
    // Handshake offered during reset must be ignored
    drive(1'b1, 1'b1, 8'h3C);
    drive(1'b1, 1'b1, 8'h3C);

    drive(1'b0, 1'b1, 8'hA5);
    repeat (20) drive(1'b0, 1'b0, DATA_W'($urandom()));

    // Back-to-back frames with in_data moving under a busy transmitter
    send_held(8'h3C);
    send_held(8'hFF);
    repeat (30) drive(1'b0, 1'b0, DATA_W'($urandom()));

    // Reset during the 4th payload bit of 8'h0F
    drive(1'b0, 1'b1, 8'h0F);
    repeat (PRE_W + 3) drive(1'b0, 1'b0, DATA_W'($urandom()));
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h81);
    repeat (25) drive(1'b0, 1'b0, 8'h00);

    drive(1'b0, 1'b1, 8'h01);
    repeat (25) drive(1'b0, 1'b0, 8'h00);

    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1, DATA_W'($urandom()));
    end

    repeat (40) drive(1'b0, 1'b0, 8'h00);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx_fsm.md
Name: serial_pattern_tx_fsm

Overview:
- FSM-based serial transmitter; the other end of the "110011" sequence detector.
- Accepts a parallel data word over a valid/ready handshake.
- Emits a fixed sync preamble, then the data word MSB-first, one bit per clock, then a programmable idle gap.
- Sits in front of any serial link whose receiver locks on the preamble using a sequence-detecting FSM.

Parameters:
- DATA_W, 8, payload width in bits (1..32).
- PRE_W, 6, preamble length in bits (1..16).
- PREAMBLE, 6'b110011, preamble pattern; sent MSB (bit PRE_W-1) first.
- GAP_CYCLES, 2, idle cycles after each frame (0..15).

Ports:
- clk  input  1  clock
- rst  input  1  reset
- in_valid  input  1  input word valid
- in_data  input  DATA_W  word to send
- in_ready  output  1  block can accept a word
- out_bit  output  1  serial data
- out_valid  output  1  out_bit carries a frame bit
- frame_done  output  1  one-cycle pulse with the last frame bit

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk.
- State after a rst edge: state=IDLE, out_valid=0, out_bit=0, frame_done=0, in_ready=1, counters=0.
- Handshakes in a cycle with rst=1 are ignored.
- States: IDLE, PRE, DATA, (PAR), GAP.
- All outputs decode from registered state, shift register and counter; there are no combinational in->out paths.
- in_ready = (state==IDLE). Transfer occurs when in_valid && in_ready at a rising edge.
- On transfer, in_data is latched into a DATA_W shift register. in_data changes after acceptance have no effect.
- Next cycle: state=PRE, bit counter=0.
- PRE: out_valid=1, out_bit=PREAMBLE[PRE_W-1-cnt]. After PRE_W cycles -> DATA, cnt=0.
- DATA: out_valid=1, out_bit=shreg[DATA_W-1]; shift left each cycle. After DATA_W cycles:
  - -> GAP if GAP_CYCLES>0, else -> IDLE.
  - -> PAR instead when the optional feature is enabled.
- frame_done=1 exactly in the cycle carrying the last frame bit: last DATA bit, or the PAR bit when parity is enabled.
- GAP: out_valid=0, out_bit=0, lasts exactly GAP_CYCLES cycles, then -> IDLE.
- IDLE: out_valid=0, out_bit=0.
- Latency: word accepted at edge T -> first preamble bit valid in cycle T+1. Frame occupies PRE_W+DATA_W(+1) consecutive valid cycles with no bubbles.
- Back-to-back: with in_valid held high, successive frames are separated by GAP_CYCLES gap cycles plus 1 IDLE acceptance cycle.
- Reset mid-frame:
  - Frame aborted; out_valid=0 from the cycle after the rst edge.
  - The partial word is discarded and never resumed.
- Counter width: clog2(max(PRE_W, DATA_W, GAP_CYCLES)+1). The counter never wraps; it is cleared on each state change.
- Unused or illegal state encodings go to IDLE.

Optional Feature:
- Macro SERIAL_PATTERN_TX_PARITY_EN.
- Defined:
  - PAR state follows DATA for one cycle.
  - out_valid=1, out_bit = XOR of the latched word (even parity over data bits only).
  - frame_done moves to the PAR cycle.
  - Frame length is PRE_W+DATA_W+1.
- Undefined: no PAR state; DATA goes directly to GAP/IDLE; frame length is PRE_W+DATA_W.

Test Plan:
- Reset, then in_valid=1, in_data=8'hA5 for one cycle -> in_ready falls next cycle. out_valid=1 for 14 cycles with out_bit = 1,1,0,0,1,1, 1,0,1,0,0,1,0,1. frame_done on the 14th. Then 2 cycles out_valid=0, then in_ready=1.
- out_bit looped into detect_6_bit_sequence_using_fsm -> detected=1 exactly one cycle after the 6th preamble bit, and no detection elsewhere for data 8'hA5.
- in_valid held high with words 8'h3C, 8'hFF -> second frame's first bit appears exactly GAP_CYCLES+2 cycles after the first frame's frame_done cycle. in_data changes during a frame are ignored.
- rst asserted in the 4th data bit cycle of frame 8'h0F -> next cycle out_valid=0, out_bit=0, in_ready=1. The next accepted word 8'h81 is transmitted in full and correctly.
- GAP_CYCLES=0 build, continuous valid -> exactly one out_valid=0 cycle between frames.
- SERIAL_PATTERN_TX_PARITY_EN defined -> 8'hA5 gives parity bit 0, 8'h01 gives parity bit 1. Frame is 15 bits; frame_done is on the parity cycle.
